// File: rtl/bus_resp_pkg.sv
// Shared encodings for the bus memory responder: access-size control codes,
// FSM states, busy pattern and small decode helpers.
package bus_resp_pkg;

  localparam logic [2:0] CTRL_B  = 3'b000;
  localparam logic [2:0] CTRL_H  = 3'b001;
  localparam logic [2:0] CTRL_W  = 3'b010;
  localparam logic [2:0] CTRL_BU = 3'b100;
  localparam logic [2:0] CTRL_HU = 3'b101;

  localparam logic [3:0] BUSY_ON = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Any ctrl code outside the five defined ones behaves as a word access.
  function automatic size_t ctrl_size(input logic [2:0] ctrl);
    case (ctrl)
      CTRL_B, CTRL_BU: return SZ_B;
      CTRL_H, CTRL_HU: return SZ_H;
      default:         return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] lo);
    case (ctrl_size(ctrl))
      SZ_H:    return lo[0];
      SZ_W:    return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bus_resp_lane.sv
// Byte-lane steering: load extract with sign/zero extension, and store
// byte-enable generation with right-aligned data replicated across lanes.
module bus_resp_lane
  import bus_resp_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data
);

  size_t       size;
  logic        sign_ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign size     = ctrl_size(ctrl);
  assign sign_ext = ~ctrl[2];

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
      SZ_H:    load_data = {{16{sign_ext & half_v[15]}}, half_v};
      default: load_data = rdata;
    endcase
  end

  // Misaligned halfword/word addresses simply fall onto their natural lanes.
  always_comb begin
    case (size)
      SZ_B: begin
        byte_en    = 4'b0001 << addr_lo;
        store_data = {4{wdata[7:0]}};
      end
      SZ_H: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side bus responder: one request at a time, programmable busy time,
// byte-enabled scratch RAM. Define BUS_RESP_ADDR_CHECK_EN to flag
// out-of-window and misaligned accesses on w_data_err.
module bus_mem_responder
  import bus_resp_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        w_data_le,
  input  logic        w_data_we,
  input  logic [31:0] w_mem_paddr,
  input  logic [2:0]  w_data_ctrl,
  input  logic [31:0] w_data_wdata,
  output logic [3:0]  w_data_busy,
  output logic [31:0] w_data_data,
  output logic        w_data_err
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t state, state_nx;

  logic [3:0]  wait_cnt;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ctrl;
  logic        req_le;
  logic        req_we;

  logic accept;
  logic do_access;
  logic do_count;
  logic finish;
  logic acc_err;

  logic [31:0]       offset;
  logic [ADDR_W-1:0] ram_idx;
  logic [31:0]       ram [DEPTH];
  logic [31:0]       ram_rdata;
  logic [31:0]       load_data;
  logic [31:0]       store_data;
  logic [3:0]        byte_en;

  // Word index wraps modulo the RAM depth.
  assign offset  = req_addr - BASE_ADDR;
  assign ram_idx = ADDR_W'(offset >> 2);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST_X) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (w_data_le | w_data_we) state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_WAIT;
      S_WAIT:   if (wait_cnt <= 4'd1) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    accept      = 1'b0;
    do_access   = 1'b0;
    do_count    = 1'b0;
    finish      = 1'b0;
    w_data_busy = 4'b0000;
    case (state)
      S_IDLE:   accept = w_data_le | w_data_we;
      S_ACCESS: begin
        do_access   = 1'b1;
        w_data_busy = BUSY_ON;
      end
      S_WAIT: begin
        w_data_busy = BUSY_ON;
        if (wait_cnt <= 4'd1) finish   = 1'b1;
        else                  do_count = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST_X) begin
      wait_cnt    <= 4'd0;
      req_addr    <= 32'd0;
      req_wdata   <= 32'd0;
      req_ctrl    <= CTRL_W;
      req_le      <= 1'b0;
      req_we      <= 1'b0;
      w_data_data <= 32'd0;
    end else begin
      if (accept) begin
        req_addr  <= w_mem_paddr;
        req_wdata <= w_data_wdata;
        req_ctrl  <= w_data_ctrl;
        req_le    <= w_data_le;
        req_we    <= w_data_we;
      end

      if (do_access)     wait_cnt <= 4'(WAIT_CYCLES);
      else if (finish)   wait_cnt <= 4'd0;
      else if (do_count) wait_cnt <= wait_cnt - 4'd1;

      // A store-only request leaves the previous load result visible.
      if (finish && req_le) w_data_data <= acc_err ? 32'd0 : load_data;
    end
  end

`ifdef BUS_RESP_ADDR_CHECK_EN
  logic err_q;

  assign acc_err = ((offset >> (ADDR_W + 2)) != 32'd0) |
                   is_misaligned(req_ctrl, req_addr[1:0]);

  always_ff @(posedge CLK) begin
    if (RST_X)       err_q <= 1'b0;
    else if (accept) err_q <= 1'b0;
    else if (finish) err_q <= acc_err;
  end

  assign w_data_err = err_q;
`else
  assign acc_err    = 1'b0;
  assign w_data_err = 1'b0;
`endif

  // Old word is captured on the same edge as the write: read-before-write.
  // NOTE: RAM contents and its read register are deliberately not reset; contents survive RST_X.
  always_ff @(posedge CLK) begin
    if (do_access) begin
      ram_rdata <= ram[ram_idx];
      if (req_we && !acc_err) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) ram[ram_idx][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

  bus_resp_lane u_lane (
    .ctrl       (req_ctrl),
    .addr_lo    (req_addr[1:0]),
    .rdata      (ram_rdata),
    .wdata      (req_wdata),
    .load_data  (load_data),
    .byte_en    (byte_en),
    .store_data (store_data)
  );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: directed cases plus randomized
// traffic compared against a byte-level reference memory model.
module tb_bus_mem_responder;

  localparam int          ADDR_W      = 6;
  localparam logic [31:0] BASE        = 32'h1000_0000;
  localparam int          WAIT_CYCLES = 2;
  localparam int          DEPTH       = 1 << ADDR_W;
  localparam int          BUSY_LEN    = WAIT_CYCLES + 1;
`ifdef BUS_RESP_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        CLK;
  logic        RST_X;
  logic        w_data_le;
  logic        w_data_we;
  logic [31:0] w_mem_paddr;
  logic [2:0]  w_data_ctrl;
  logic [31:0] w_data_wdata;
  logic [3:0]  w_data_busy;
  logic [31:0] w_data_data;
  logic        w_data_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_data;

  bus_mem_responder #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .CLK          (CLK),
    .RST_X        (RST_X),
    .w_data_le    (w_data_le),
    .w_data_we    (w_data_we),
    .w_mem_paddr  (w_mem_paddr),
    .w_data_ctrl  (w_data_ctrl),
    .w_data_wdata (w_data_wdata),
    .w_data_busy  (w_data_busy),
    .w_data_data  (w_data_data),
    .w_data_err   (w_data_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] ctrl);
    case (ctrl)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int model_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'((off / 4) % DEPTH);
  endfunction

  function automatic bit model_bad(input logic [31:0] addr, input logic [2:0] ctrl);
    logic [31:0] off;
    off = addr - BASE;
    if (off >= 32'(DEPTH * 4)) return 1'b1;
    return (int'(off % 4) % size_bytes(ctrl)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] ctrl);
    logic [31:0] word, val;
    int sz, first;
    sz    = size_bytes(ctrl);
    word  = model_mem[model_idx(addr)];
    first = (int'((addr - BASE) % 4) / sz) * sz;
    val   = 32'd0;
    for (int i = 0; i < sz; i++) val[8*i +: 8] = word[8*(first+i) +: 8];
    if (ctrl[2] == 1'b0 && sz < 4 && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8*sz));
    return val;
  endfunction

  task automatic model_op(input logic le, input logic we, input logic [31:0] addr,
                          input logic [2:0] ctrl, input logic [31:0] wdata,
                          output logic [31:0] exp_data, output logic exp_err);
    logic [31:0] word;
    int sz, first, idx;
    bit bad;
    bad      = CHECK_EN && model_bad(addr, ctrl);
    exp_err  = bad;
    exp_data = le ? (bad ? 32'd0 : model_load(addr, ctrl)) : last_data;
    if (we && !bad) begin
      sz    = size_bytes(ctrl);
      first = (int'((addr - BASE) % 4) / sz) * sz;
      idx   = model_idx(addr);
      word  = model_mem[idx];
      for (int i = 0; i < sz; i++) word[8*(first+i) +: 8] = wdata[8*i +: 8];
      model_mem[idx] = word;
    end
    last_data = exp_data;
  endtask

  // ---------------- bus driver ----------------
  // Raises the request on a falling edge, holds it hold_extra cycles past the
  // first busy sample, and returns on the falling edge where busy is low again.
  task automatic bus_op(input logic le, input logic we, input logic [31:0] addr,
                        input logic [2:0] ctrl, input logic [31:0] wdata, input int hold_extra,
                        output int busy_cycles, output bit busy_bad);
    int n;
    int hold;
    busy_cycles = 0;
    busy_bad    = 1'b0;
    hold        = hold_extra;
    @(negedge CLK);
    w_data_le    = le;
    w_data_we    = we;
    w_mem_paddr  = addr;
    w_data_ctrl  = ctrl;
    w_data_wdata = wdata;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (w_data_busy === 4'b0000 && n < 8);
    while (w_data_busy !== 4'b0000 && busy_cycles < 40) begin
      if (w_data_busy !== 4'b0001) busy_bad = 1'b1;
      busy_cycles++;
      if (hold == 0) begin
        w_data_le = 1'b0;
        w_data_we = 1'b0;
      end else begin
        hold--;
      end
      @(negedge CLK);
    end
    w_data_le = 1'b0;
    w_data_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_X        = 1'b1;
    w_data_le    = 1'b0;
    w_data_we    = 1'b0;
    w_mem_paddr  = 32'd0;
    w_data_ctrl  = 3'b010;
    w_data_wdata = 32'd0;
    last_data    = 32'd0;
    repeat (3) @(negedge CLK);
    checks++;
    if (w_data_busy !== 4'b0000) begin
      errors++; $display("FAIL reset_busy: got %h expected %h", w_data_busy, 4'b0000);
    end
    checks++;
    if (w_data_data !== 32'd0) begin
      errors++; $display("FAIL reset_data: got %h expected %h", w_data_data, 32'd0);
    end
    checks++;
    if (w_data_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b expected 0", w_data_err);
    end
    RST_X = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] wd, exp_d;
    logic exp_e;
    int cyc;
    bit bad;
    for (int i = 0; i < DEPTH; i++) begin
      wd = $urandom;
      model_op(1'b0, 1'b1, BASE + 32'(4*i), 3'b010, wd, exp_d, exp_e);
      bus_op(1'b0, 1'b1, BASE + 32'(4*i), 3'b010, wd, 0, cyc, bad);
      checks++;
      if (cyc != BUSY_LEN || bad) begin
        errors++; $display("FAIL fill_busy[%0d]: got %0d cycles (bad=%0b) expected %0d", i, cyc, bad, BUSY_LEN);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] exp_d;
    logic exp_e;
    int cyc;
    bit bad;
    logic [31:0] a;
    a = BASE + 32'h10;

    model_op(1'b0, 1'b1, a, 3'b010, 32'hDEADBEEF, exp_d, exp_e);
    bus_op(1'b0, 1'b1, a, 3'b010, 32'hDEADBEEF, 0, cyc, bad);
    model_op(1'b1, 1'b0, a, 3'b010, 32'd0, exp_d, exp_e);
    bus_op(1'b1, 1'b0, a, 3'b010, 32'd0, 0, cyc, bad);
    checks++;
    if (cyc != 3 || bad) begin
      errors++; $display("FAIL lw_busy_len: got %0d (bad=%0b) expected 3", cyc, bad);
    end
    checks++;
    if (w_data_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_data: got %h expected %h", w_data_data, 32'hDEADBEEF);
    end

    model_op(1'b1, 1'b0, a + 32'd3, 3'b000, 32'd0, exp_d, exp_e);
    bus_op(1'b1, 1'b0, a + 32'd3, 3'b000, 32'd0, 0, cyc, bad);
    checks++;
    if (w_data_data !== 32'hFFFFFFDE) begin
      errors++; $display("FAIL lb_sext: got %h expected %h", w_data_data, 32'hFFFFFFDE);
    end

    model_op(1'b1, 1'b0, a + 32'd3, 3'b100, 32'd0, exp_d, exp_e);
    bus_op(1'b1, 1'b0, a + 32'd3, 3'b100, 32'd0, 0, cyc, bad);
    checks++;
    if (w_data_data !== 32'h000000DE) begin
      errors++; $display("FAIL lbu_zext: got %h expected %h", w_data_data, 32'h000000DE);
    end

    model_op(1'b1, 1'b0, a + 32'd2, 3'b101, 32'd0, exp_d, exp_e);
    bus_op(1'b1, 1'b0, a + 32'd2, 3'b101, 32'd0, 0, cyc, bad);
    checks++;
    if (w_data_data !== 32'h0000DEAD) begin
      errors++; $display("FAIL lhu_hi: got %h expected %h", w_data_data, 32'h0000DEAD);
    end

    model_op(1'b0, 1'b1, a + 32'd1, 3'b000, 32'hA5A5A555, exp_d, exp_e);
    bus_op(1'b0, 1'b1, a + 32'd1, 3'b000, 32'hA5A5A555, 0, cyc, bad);
    model_op(1'b1, 1'b0, a, 3'b010, 32'd0, exp_d, exp_e);
    bus_op(1'b1, 1'b0, a, 3'b010, 32'd0, 0, cyc, bad);
    checks++;
    if (w_data_data !== 32'hDEAD55EF) begin
      errors++; $display("FAIL sb_lanes: got %h expected %h", w_data_data, 32'hDEAD55EF);
    end
  endtask

  task automatic test_swap();
    logic [31:0] exp_d;
    logic exp_e;
    int cyc;
    bit bad;
    logic [31:0] a;
    a = BASE + 32'h20;
    model_op(1'b0, 1'b1, a, 3'b010, 32'h7, exp_d, exp_e);
    bus_op(1'b0, 1'b1, a, 3'b010, 32'h7, 0, cyc, bad);
    model_op(1'b1, 1'b1, a, 3'b010, 32'h1, exp_d, exp_e);
    bus_op(1'b1, 1'b1, a, 3'b010, 32'h1, 0, cyc, bad);
    checks++;
    if (w_data_data !== 32'h7) begin
      errors++; $display("FAIL swap_old: got %h expected %h", w_data_data, 32'h7);
    end
    model_op(1'b1, 1'b0, a, 3'b010, 32'd0, exp_d, exp_e);
    bus_op(1'b1, 1'b0, a, 3'b010, 32'd0, 0, cyc, bad);
    checks++;
    if (w_data_data !== 32'h1) begin
      errors++; $display("FAIL swap_new: got %h expected %h", w_data_data, 32'h1);
    end
    // A store-only request must not disturb the last load result.
    model_op(1'b0, 1'b1, a + 32'd4, 3'b001, 32'h0000BEEF, exp_d, exp_e);
    bus_op(1'b0, 1'b1, a + 32'd4, 3'b001, 32'h0000BEEF, 0, cyc, bad);
    checks++;
    if (w_data_data !== 32'h1) begin
      errors++; $display("FAIL store_keeps_data: got %h expected %h", w_data_data, 32'h1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    logic exp_e;
    int cyc;
    int extra;
    bit bad;
    model_op(1'b1, 1'b0, BASE + 32'h10, 3'b010, 32'd0, exp_d, exp_e);
    bus_op(1'b1, 1'b0, BASE + 32'h10, 3'b010, 32'd0, 2, cyc, bad);
    checks++;
    if (cyc != BUSY_LEN || bad || w_data_data !== exp_d) begin
      errors++; $display("FAIL held_le: got %0d cycles data %h expected %0d cycles data %h", cyc, w_data_data, BUSY_LEN, exp_d);
    end
    extra = 0;
    repeat (4) begin
      if (w_data_busy !== 4'b0000) extra++;
      @(negedge CLK);
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL held_le_retrigger: got %0d busy cycles expected 0", extra);
    end
    model_op(1'b1, 1'b0, BASE + 32'h20, 3'b010, 32'd0, exp_d, exp_e);
    bus_op(1'b1, 1'b0, BASE + 32'h20, 3'b010, 32'd0, 0, cyc, bad);
    model_op(1'b1, 1'b0, BASE + 32'h13, 3'b000, 32'd0, exp_d, exp_e);
    bus_op(1'b1, 1'b0, BASE + 32'h13, 3'b000, 32'd0, 0, cyc, bad);
    checks++;
    if (cyc != BUSY_LEN || bad || w_data_data !== exp_d) begin
      errors++; $display("FAIL quick_reissue: got %0d cycles data %h expected %0d cycles data %h", cyc, w_data_data, BUSY_LEN, exp_d);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d;
    logic exp_e;
    int cyc;
    bit bad;
    model_op(1'b0, 1'b1, BASE + 32'(DEPTH*4), 3'b010, 32'hC0FFEE11, exp_d, exp_e);
    bus_op(1'b0, 1'b1, BASE + 32'(DEPTH*4), 3'b010, 32'hC0FFEE11, 0, cyc, bad);
    checks++;
    if (w_data_err !== exp_e) begin
      errors++; $display("FAIL wrap_store_err: got %b expected %b", w_data_err, exp_e);
    end
    model_op(1'b1, 1'b0, BASE + 32'(DEPTH*4), 3'b010, 32'd0, exp_d, exp_e);
    bus_op(1'b1, 1'b0, BASE + 32'(DEPTH*4), 3'b010, 32'd0, 0, cyc, bad);
    checks++;
    if (w_data_data !== exp_d || w_data_err !== exp_e) begin
      errors++; $display("FAIL wrap_load: got %h err %b expected %h err %b", w_data_data, w_data_err, exp_d, exp_e);
    end
    model_op(1'b1, 1'b0, BASE, 3'b010, 32'd0, exp_d, exp_e);
    bus_op(1'b1, 1'b0, BASE, 3'b010, 32'd0, 0, cyc, bad);
    checks++;
    if (w_data_data !== exp_d || w_data_err !== exp_e) begin
      errors++; $display("FAIL wrap_word0: got %h err %b expected %h err %b", w_data_data, w_data_err, exp_d, exp_e);
    end
  endtask

  task automatic test_random();
    logic [2:0]  ctrl_tab [8];
    logic [31:0] addr, wd, exp_d;
    logic [2:0]  ctrl;
    logic        le, we, exp_e;
    int cyc, kind;
    bit bad;
    ctrl_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      addr = BASE + 32'($urandom_range(0, DEPTH*4 - 1));
      if (kind == 8) addr = addr + 32'(DEPTH*4*$urandom_range(1, 3));
      if (kind == 9) addr = BASE - 32'($urandom_range(1, 16));
      ctrl = ctrl_tab[$urandom_range(0, 7)];
      case ($urandom_range(0, 2))
        0:       begin le = 1'b1; we = 1'b0; end
        1:       begin le = 1'b0; we = 1'b1; end
        default: begin le = 1'b1; we = 1'b1; end
      endcase
      wd = $urandom;
      model_op(le, we, addr, ctrl, wd, exp_d, exp_e);
      bus_op(le, we, addr, ctrl, wd, 0, cyc, bad);
      checks++;
      if (cyc != BUSY_LEN || bad) begin
        errors++; $display("FAIL rand_busy[%0d]: got %0d cycles (bad=%0b) expected %0d", i, cyc, bad, BUSY_LEN);
      end
      checks++;
      if (w_data_data !== exp_d) begin
        errors++; $display("FAIL rand_data[%0d] le=%b we=%b ctrl=%b addr=%h: got %h expected %h", i, le, we, ctrl, addr, w_data_data, exp_d);
      end
      checks++;
      if (w_data_err !== exp_e) begin
        errors++; $display("FAIL rand_err[%0d]: got %b expected %b", i, w_data_err, exp_e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_d;
    logic exp_e;
    int n, cyc;
    bit bad;
    @(negedge CLK);
    w_data_le   = 1'b1;
    w_mem_paddr = BASE + 32'h10;
    w_data_ctrl = 3'b010;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (w_data_busy === 4'b0000 && n < 8);
    w_data_le = 1'b0;
    checks++;
    if (w_data_busy !== 4'b0001) begin
      errors++; $display("FAIL midreset_start: got %h expected %h", w_data_busy, 4'b0001);
    end
    @(negedge CLK);
    RST_X = 1'b1;
    @(negedge CLK);
    checks++;
    if (w_data_busy !== 4'b0000 || w_data_data !== 32'd0) begin
      errors++; $display("FAIL midreset_clear: got busy %h data %h expected busy 0 data 0", w_data_busy, w_data_data);
    end
    RST_X     = 1'b0;
    last_data = 32'd0;
    model_op(1'b1, 1'b0, BASE + 32'h10, 3'b010, 32'd0, exp_d, exp_e);
    bus_op(1'b1, 1'b0, BASE + 32'h10, 3'b010, 32'd0, 0, cyc, bad);
    checks++;
    if (cyc != BUSY_LEN || bad || w_data_data !== exp_d) begin
      errors++; $display("FAIL midreset_after: got %0d cycles data %h expected %0d cycles data %h", cyc, w_data_data, BUSY_LEN, exp_d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_swap();
    test_back_to_back();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
